// File: rtl/video_frame_capture_if.sv
// Video input and pixel-memory write bus of the frame capture block.
interface video_frame_capture_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              start;
    logic              hsync;
    logic              vsync;
    logic              den;
    logic [23:0]       rgb_in;
    logic              write_enable;
    logic [ADDR_W-1:0] address;
    logic [7:0]        data_output;
    logic              busy;
    logic              frame_done;
    logic              short_frame;

    modport master (
        output start, hsync, vsync, den, rgb_in,
        input  write_enable, address, data_output, busy, frame_done, short_frame
    );

    modport slave (
        input  start, hsync, vsync, den, rgb_in,
        output write_enable, address, data_output, busy, frame_done, short_frame
    );
endinterface

// File: rtl/video_frame_capture.sv
// Captures one video frame on request, converting RGB to 8-bit grayscale and
// issuing row-major pixel-memory writes through a two-stage pipeline.
module video_frame_capture #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    video_frame_capture_if.slave bus
);
    localparam int unsigned COL_W = $clog2(H_ACTIVE + 1);
    localparam int unsigned ROW_W = $clog2(V_ACTIVE + 1);
    localparam logic [COL_W-1:0]  COL_END   = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              vsync_q, den_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] line_base_q;
    logic              s0_valid_q;
    logic [ADDR_W-1:0] s0_addr_q;
    logic [23:0]       s0_rgb_q;
    logic              we_q, busy_q, frame_done_q, short_frame_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic              frame_start, accept, abort, clear_cnt, done_pulse;
    logic [15:0]       gray_sum;
    logic              unused_hsync;

    // Frame starts on the rising edge of vsync (end of the sync pulse).
    assign frame_start  = !vsync_q && bus.vsync;
    assign unused_hsync = bus.hsync;

    assign gray_sum = 16'd77  * {8'd0, s0_rgb_q[23:16]}
                    + 16'd150 * {8'd0, s0_rgb_q[15:8]}
                    + 16'd29  * {8'd0, s0_rgb_q[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        abort      = 1'b0;
        clear_cnt  = 1'b0;
        done_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (frame_start) begin
                    state_d   = CAPTURE;
                    clear_cnt = 1'b1;
                end
            end
            CAPTURE: begin
                if (frame_start) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (bus.den && (col_q < COL_END)) begin
                    accept = 1'b1;
                    if ((row_q == ROW_LAST) && (col_q == COL_LAST)) state_d = DONE;
                end
            end
            DONE: begin
                // Last pixel leaves stage 0 this cycle; frame_done follows its write.
                if (!s0_valid_q) begin
                    state_d    = IDLE;
                    done_pulse = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q       <= 1'b1;
            den_q         <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            line_base_q   <= '0;
            s0_valid_q    <= 1'b0;
            s0_addr_q     <= '0;
            s0_rgb_q      <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            short_frame_q <= 1'b0;
        end else begin
            vsync_q <= bus.vsync;
            den_q   <= bus.den;

            // Column saturates at H_ACTIVE so overlong lines are discarded.
            if (clear_cnt) begin
                col_q       <= '0;
                row_q       <= '0;
                line_base_q <= '0;
            end else if (state_q == CAPTURE) begin
                if (den_q && !bus.den) begin
                    col_q <= '0;
                    if (col_q != '0) begin
                        row_q       <= row_q + ROW_W'(1);
                        line_base_q <= line_base_q + LINE_STEP;
                    end
                end else if (bus.den && (col_q < COL_END)) begin
                    col_q <= col_q + COL_W'(1);
                end
            end

            s0_valid_q <= accept;
            if (accept) begin
                s0_addr_q <= line_base_q + ADDR_W'(col_q);
                s0_rgb_q  <= bus.rgb_in;
            end

            // An abort drops the pixel still in stage 0.
            we_q <= s0_valid_q && !abort;
            if (s0_valid_q && !abort) begin
                addr_q <= s0_addr_q;
                data_q <= gray_sum[15:8];
            end

            busy_q       <= (state_d != IDLE);
            frame_done_q <= done_pulse;
            if (abort)                             short_frame_q <= 1'b1;
            else if (state_q == IDLE && bus.start) short_frame_q <= 1'b0;
        end
    end

    assign bus.write_enable = we_q;
    assign bus.address      = addr_q;
    assign bus.data_output  = data_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.short_frame  = short_frame_q;
endmodule

// File: tb/tb_video_frame_capture.sv
// Scoreboard bench for video_frame_capture with a 4x2 frame.
module tb_video_frame_capture;
    localparam int unsigned H  = 4;
    localparam int unsigned V  = 2;
    localparam int unsigned AW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    video_frame_capture_if #(.ADDR_W(AW)) bus ();

    video_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   n_writes = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   last_we_cyc = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write and frame_done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.write_enable === 1'b1) begin
            n_writes++;
            last_we_cyc = cyc;
            check("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("address", 32'(bus.address), 32'(e.addr));
                check("data_output", 32'(bus.data_output), 32'(e.data));
                check("write_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (bus.frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_low_at_done", 32'(bus.busy), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input logic [23:0] rgb, input bit exp_w, input int addr, input logic [7:0] data);
        exp_t e;
        bus.den    = 1'b1;
        bus.rgb_in = rgb;
        if (exp_w) begin
            e.addr = AW'(addr);
            e.data = data;
            e.cyc  = cyc + 2;
            sb.push_back(e);
        end
        tick();
    endtask

    task automatic blank(input int n);
        bus.den    = 1'b0;
        bus.rgb_in = '0;
        bus.hsync  = 1'b0;
        tick();
        bus.hsync  = 1'b1;
        for (int i = 1; i < n; i++) tick();
    endtask

    task automatic start_frame();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        bus.vsync = 1'b0;
        tick();
        tick();
        bus.vsync = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
        tick();
        tick();
        check("frame_done_count", 32'(done_cnt - d0), 32'd1);
        check("done_after_last_write", 32'(done_cyc - last_we_cyc), 32'd1);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 32'(bus.write_enable), 32'd0);
        check({tag, "_addr"}, 32'(bus.address), 32'd0);
        check({tag, "_data"}, 32'(bus.data_output), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.frame_done), 32'd0);
        check({tag, "_short"}, 32'(bus.short_frame), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [23:0] colors [4];
        logic [7:0]  grays  [4];
        int d0;
        int w0;
        colors = '{24'hFFFFFF, 24'h000000, 24'h00FF00, 24'h0000FF};
        grays  = '{8'hFF, 8'h00, 8'h95, 8'h1C};

        reset = 1'b1;
        bus.start = 1'b0; bus.hsync = 1'b1; bus.vsync = 1'b1; bus.den = 1'b0; bus.rgb_in = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // No start: syncs and den toggle, nothing may be written.
        for (int i = 0; i < 12; i++) begin
            bus.vsync  = (i % 3) != 0;
            bus.den    = i[0];
            bus.rgb_in = 24'hFF0000;
            tick();
        end
        bus.vsync = 1'b1; bus.den = 1'b0;
        repeat (3) tick();
        check("idle_no_writes", 32'(n_writes), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Full red frame.
        start_frame();
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) pixel(24'hFF0000, 1'b1, i, 8'h4C);
        blank(2);
        for (int i = 0; i < 4; i++) pixel(24'hFF0000, 1'b1, 4 + i, 8'h4C);
        blank(1);
        wait_done(d0);
        check("red_frame_writes", 32'(n_writes), 32'd8);

        // Grayscale corner colours.
        start_frame();
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) pixel(colors[i], 1'b1, i, grays[i]);
        blank(3);
        for (int i = 0; i < 4; i++) pixel(colors[3 - i], 1'b1, 4 + i, grays[3 - i]);
        blank(1);
        wait_done(d0);

        // Overlong first line: pixels 5 and 6 are dropped.
        start_frame();
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) pixel(24'h0000FF, i < 4, i, 8'h1C);
        blank(2);
        for (int i = 0; i < 4; i++) pixel(24'h00FF00, 1'b1, 4 + i, 8'h95);
        blank(1);
        wait_done(d0);

        // Short frame: new vsync pulse after 5 pixels.
        start_frame();
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) pixel(24'hFFFFFF, 1'b1, i, 8'hFF);
        blank(2);
        pixel(24'hFFFFFF, 1'b1, 4, 8'hFF);
        blank(3);
        bus.vsync = 1'b0;
        tick();
        bus.vsync = 1'b1;
        tick();
        tick();
        check("short_frame_set", 32'(bus.short_frame), 32'd1);
        check("short_busy", 32'(bus.busy), 32'd0);
        check("short_sb_drained", 32'(sb.size()), 32'd0);
        w0 = n_writes;
        for (int i = 0; i < 3; i++) pixel(24'h123456, 1'b0, 0, 8'h00);
        blank(3);
        check("short_no_done", 32'(done_cnt - d0), 32'd0);
        check("short_idle_no_writes", 32'(n_writes - w0), 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("short_cleared_by_start", 32'(bus.short_frame), 32'd0);
        check("wait_busy", 32'(bus.busy), 32'd1);

        // Reset while the third pixel of line 0 is on the bus.
        bus.vsync = 1'b0;
        tick();
        bus.vsync = 1'b1;
        tick();
        pixel(24'h00FF00, 1'b1, 0, 8'h95);
        pixel(24'hFF0000, 1'b0, 1, 8'h4C);
        bus.den    = 1'b1;
        bus.rgb_in = 24'h0000FF;
        #6;
        w0 = n_writes;
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        tick();
        tick();
        check_reset_outputs("abort_hold");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) pixel(24'hFFFFFF, 1'b0, 0, 8'h00);
        blank(3);
        check("abort_no_writes", 32'(n_writes - w0), 32'd0);
        check("abort_idle", 32'(bus.busy), 32'd0);
        check("abort_sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/video_frame_capture.md
VIDEO_FRAME_CAPTURE -- requirements
Module: video_frame_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 19, pixel address width; H_ACTIVE*V_ACTIVE SHALL fit in ADDR_W bits.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to capture the next full frame.
REQ-007 hsync  input  1  horizontal sync, active-low.
REQ-008 vsync  input  1  vertical sync, active-low.
REQ-009 den  input  1  data enable; rgb_in valid when high.
REQ-010 rgb_in  input  24  pixel {R[23:16], G[15:8], B[7:0]}.
REQ-011 write_enable  output  1  pixel write strobe to pixel memory.
REQ-012 address  output  ADDR_W  pixel write address, row-major.
REQ-013 data_output  output  8  grayscale pixel.
REQ-014 busy  output  1  high in WAIT_FRAME and CAPTURE.
REQ-015 frame_done  output  1  one-cycle pulse after last pixel write of a complete frame.
REQ-016 short_frame  output  1  sticky error: frame ended before H_ACTIVE*V_ACTIVE pixels; cleared by start.

Function
REQ-017 SHALL implement states IDLE, WAIT_FRAME, CAPTURE, DONE.
REQ-018 IDLE -> WAIT_FRAME on start; start in any other state SHALL be ignored.
REQ-019 vsync SHALL be registered each cycle; frame-start event = registered vsync 0 and current vsync 1 (end of sync pulse).
REQ-020 WAIT_FRAME -> CAPTURE on frame-start event; pixel and line counters cleared to 0 on this transition.
REQ-021 In CAPTURE, each cycle with den=1 and column < H_ACTIVE SHALL accept one pixel; den pixels at column >= H_ACTIVE SHALL be discarded.
REQ-022 Column counter SHALL reset to 0 on den falling edge; row counter SHALL increment on den falling edge if column > 0.
REQ-023 address of an accepted pixel SHALL equal row*H_ACTIVE + column, maintained incrementally (no multiplier).
REQ-024 Grayscale SHALL be (77*R + 150*G + 29*B) >> 8, 16-bit unsigned intermediate, result 8 bits, no rounding.
REQ-025 Pipeline: pixel accepted at cycle N SHALL appear as write_enable=1 with its address and data_output at cycle N+2; throughput one pixel per clock.
REQ-026 After the accepted pixel with address H_ACTIVE*V_ACTIVE-1: CAPTURE -> DONE; further den pixels discarded.
REQ-027 DONE SHALL wait until pipeline drains (last write issued), assert frame_done for exactly one cycle, then -> IDLE.
REQ-028 Frame-start event in CAPTURE before the last pixel SHALL set short_frame, discard in-flight stage-0 acceptance, let issued writes complete, -> IDLE without frame_done.
REQ-029 hsync SHALL not affect counting; it is accepted for interface completeness only.
REQ-030 write_enable SHALL be 0 in IDLE and WAIT_FRAME except for draining writes.

Reset
REQ-031 While reset=1: state IDLE, write_enable=0, address=0, data_output=0, busy=0, frame_done=0, short_frame=0, counters 0, registered vsync=1, pipeline valids 0.
REQ-032 Reset asserted mid-CAPTURE SHALL abort immediately; no write_enable after reset assertion; first cycle after release is IDLE.

Verification (H_ACTIVE=4, V_ACTIVE=2)
REQ-033 Reset release, no start, toggle syncs and den -> write_enable stays 0, busy 0.
REQ-034 start, vsync pulse, 2 lines of 4 den pixels rgb=FF0000 -> 8 writes, addresses 0..7, data_output=0x4C, each 2 cycles after den; frame_done one cycle after last write; busy falls with it.
REQ-035 rgb_in FFFFFF -> data_output 0xFF; 000000 -> 0x00; 00FF00 -> 0x95; 0000FF -> 0x1C.
REQ-036 Line with 6 den pixels -> only first 4 written; next line starts at address 4.
REQ-037 New vsync pulse after 5 pixels -> short_frame=1, no frame_done, state IDLE; next start clears short_frame.
REQ-038 reset asserted during the 3rd pixel of line 0 -> no further writes, all outputs at reset values.
